// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-Lite request arbiter: response codes, FSM states, default widths.
package axi_lite_pkg;

   localparam int unsigned DEF_N_REQ  = 2;
   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned RESP_W     = 2;
   localparam int unsigned PROT_W     = 3;

   localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
   localparam logic [PROT_W-1:0] PROT_NONE   = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_ACK
   } state_e;

   // Index width for an n-way selector; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin picker: combinational choice starting at a registered pointer.
module rr_arbiter
   import axi_lite_pkg::*;
#(
   parameter int unsigned N = DEF_N_REQ,
   localparam int unsigned IDX_W = idx_width(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic             gnt_valid_c,
   output logic [IDX_W-1:0] gnt_idx_c
);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [IDX_W-1:0] cand;

   // First set request at or after the pointer wins; pointer moves past the winner on advance.
   always_comb begin
      gnt_valid_c = 1'b0;
      gnt_idx_c   = '0;
      cand        = '0;
      ptr_d       = ptr_q;
      for (int unsigned i = 0; i < N; i++) begin
         cand = IDX_W'((32'(ptr_q) + i) % N);
         if (!gnt_valid_c && req[cand]) begin
            gnt_valid_c = 1'b1;
            gnt_idx_c   = cand;
         end
      end
      if (advance && gnt_valid_c) begin
         ptr_d = IDX_W'((32'(gnt_idx_c) + 32'd1) % N);
      end
   end

   // Pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// Arbitrates N simple request ports onto one AXI-Lite master, one transaction at a time.
module axi_lite_req_arbiter
   import axi_lite_pkg::*;
#(
   parameter int unsigned N_REQ  = DEF_N_REQ,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   localparam int unsigned STRB_W = DATA_W / 8,
   localparam int unsigned IDX_W  = idx_width(N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          req_we,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   input  logic [N_REQ*STRB_W-1:0]   req_wstrb,
   output logic [N_REQ-1:0]          ack,
   output logic [DATA_W-1:0]         ack_rdata,
   output logic [RESP_W-1:0]         ack_resp,
   output logic [ADDR_W-1:0]         m_AWADDR,
   output logic [PROT_W-1:0]         m_AWPROT,
   output logic                      m_AWVALID,
   input  logic                      m_AWREADY,
   output logic [DATA_W-1:0]         m_WDATA,
   output logic [STRB_W-1:0]         m_WSTRB,
   output logic                      m_WVALID,
   input  logic                      m_WREADY,
   output logic                      m_BREADY,
   input  logic                      m_BVALID,
   input  logic [RESP_W-1:0]         m_BRESP,
   output logic [ADDR_W-1:0]         m_ARADDR,
   output logic [PROT_W-1:0]         m_ARPROT,
   output logic                      m_ARVALID,
   input  logic                      m_ARREADY,
   output logic                      m_RREADY,
   input  logic                      m_RVALID,
   input  logic [DATA_W-1:0]         m_RDATA,
   input  logic [RESP_W-1:0]         m_RRESP,
   output logic                      busy,
   output logic [IDX_W-1:0]          grant_idx
);

   state_e              state_q,     state_d;
   logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
   logic [ADDR_W-1:0]   addr_q,      addr_d;
   logic [DATA_W-1:0]   wdata_q,     wdata_d;
   logic [STRB_W-1:0]   wstrb_q,     wstrb_d;
   logic                awvalid_q,   awvalid_d;
   logic                wvalid_q,    wvalid_d;
   logic                bready_q,    bready_d;
   logic                arvalid_q,   arvalid_d;
   logic                rready_q,    rready_d;
   logic [N_REQ-1:0]    ack_q,       ack_d;
   logic [DATA_W-1:0]   ack_rdata_q, ack_rdata_d;
   logic [RESP_W-1:0]   ack_resp_q,  ack_resp_d;
   logic                busy_q,      busy_d;

   logic                gnt_valid_c;
   logic [IDX_W-1:0]    gnt_idx_c;
   logic                advance_c;

   logic [ADDR_W-1:0]   addr_arr  [N_REQ];
   logic [DATA_W-1:0]   wdata_arr [N_REQ];
   logic [STRB_W-1:0]   wstrb_arr [N_REQ];

   // Split the packed per-requester buses so the grantee can be selected by index.
   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
      assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
      assign wstrb_arr[g] = req_wstrb[g*STRB_W +: STRB_W];
   end

   rr_arbiter #(
      .N (N_REQ)
   ) u_rr_arbiter (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .advance     (advance_c),
      .gnt_valid_c (gnt_valid_c),
      .gnt_idx_c   (gnt_idx_c)
   );

   // Next-state and next-output logic; every output is computed one cycle ahead and registered.
   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      ack_d       = '0;
      ack_rdata_d = '0;
      ack_resp_d  = RESP_OKAY;
      advance_c   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (gnt_valid_c) begin
               advance_c   = 1'b1;
               grant_idx_d = gnt_idx_c;
               addr_d      = addr_arr[gnt_idx_c];
               wdata_d     = wdata_arr[gnt_idx_c];
               wstrb_d     = wstrb_arr[gnt_idx_c];
               if (req_we[gnt_idx_c]) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = ST_WR_ADDR;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = ST_RD_ADDR;
               end
            end
         end
         ST_WR_ADDR: begin
            // AW and W complete independently, in either order or together.
            awvalid_d = awvalid_q & ~m_AWREADY;
            wvalid_d  = wvalid_q & ~m_WREADY;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            if (m_BVALID) begin
               bready_d   = 1'b0;
               ack_d      = N_REQ'(1) << grant_idx_q;
               ack_resp_d = m_BRESP;
               state_d    = ST_ACK;
            end
         end
         ST_RD_ADDR: begin
            if (m_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            if (m_RVALID) begin
               rready_d    = 1'b0;
               ack_d       = N_REQ'(1) << grant_idx_q;
               ack_rdata_d = m_RDATA;
               ack_resp_d  = m_RRESP;
               state_d     = ST_ACK;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers, cleared immediately by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         grant_idx_q <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         ack_q       <= '0;
         ack_rdata_q <= '0;
         ack_resp_q  <= RESP_OKAY;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         ack_q       <= ack_d;
         ack_rdata_q <= ack_rdata_d;
         ack_resp_q  <= ack_resp_d;
         busy_q      <= busy_d;
      end
   end

   assign ack       = ack_q;
   assign ack_rdata = ack_rdata_q;
   assign ack_resp  = ack_resp_q;
   assign m_AWADDR  = addr_q;
   assign m_AWPROT  = PROT_NONE;
   assign m_AWVALID = awvalid_q;
   assign m_WDATA   = wdata_q;
   assign m_WSTRB   = wstrb_q;
   assign m_WVALID  = wvalid_q;
   assign m_BREADY  = bready_q;
   assign m_ARADDR  = addr_q;
   assign m_ARPROT  = PROT_NONE;
   assign m_ARVALID = arvalid_q;
   assign m_RREADY  = rready_q;
   assign busy      = busy_q;
   assign grant_idx = grant_idx_q;

endmodule

// File: doc/axi_lite_req_arbiter.md
AXI_LITE_REQ_ARBITER -- requirements
Module: axi_lite_req_arbiter

Interface
REQ-001 Parameter N_REQ, default 2, number of requesters (2..8).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width; WSTRB width DATA_W/8.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req  in  N_REQ  per-requester transaction request, level, held until ack.
REQ-007 req_we  in  N_REQ  per-requester 1 = write, 0 = read.
REQ-008 req_addr  in  N_REQ*ADDR_W  per-requester address, packed, requester 0 in LSBs.
REQ-009 req_wdata  in  N_REQ*DATA_W  per-requester write data, packed.
REQ-010 req_wstrb  in  N_REQ*DATA_W/8  per-requester write strobes, packed.
REQ-011 ack  out  N_REQ  one-cycle completion pulse to the granted requester.
REQ-012 ack_rdata  out  DATA_W  read data, valid with ack; zero for writes.
REQ-013 ack_resp  out  2  BRESP/RRESP of the completed transaction, valid with ack.
REQ-014 m_AWADDR/m_AWPROT/m_AWVALID  out  ADDR_W/3/1, m_AWREADY in 1  write-address channel.
REQ-015 m_WDATA/m_WSTRB/m_WVALID  out  DATA_W/DATA_W/8/1, m_WREADY in 1  write-data channel.
REQ-016 m_BREADY out 1, m_BVALID in 1, m_BRESP in 2  write-response channel.
REQ-017 m_ARADDR/m_ARPROT/m_ARVALID  out  ADDR_W/3/1, m_ARREADY in 1  read-address channel.
REQ-018 m_RREADY out 1, m_RVALID in 1, m_RDATA in DATA_W, m_RRESP in 2  read-data channel.
REQ-019 busy out 1, grant_idx out $clog2(N_REQ)  status: transaction in flight, current/last grantee.

Function
REQ-020 FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, ACK; all outputs registered.
REQ-021 IDLE with any req set: round-robin pick starting at pointer; capture we/addr/wdata/wstrb of grantee; go to WR_ADDR (we=1) or RD_ADDR (we=0).
REQ-022 Pointer updates to (grantee+1) mod N_REQ on grant; reset value 0.
REQ-023 WR_ADDR: m_AWVALID and m_WVALID rise together one cycle after grant; each drops independently after its own handshake; go to WR_RESP when both handshakes are complete, including same-cycle or opposite-order completion.
REQ-024 WR_RESP: m_BREADY=1; on m_BVALID capture m_BRESP, go to ACK.
REQ-025 RD_ADDR: m_ARVALID=1 until m_ARREADY; then RD_DATA.
REQ-026 RD_DATA: m_RREADY=1; on m_RVALID capture m_RDATA/m_RRESP, go to ACK.
REQ-027 ACK: ack[grantee]=1 for exactly one cycle with ack_rdata/ack_resp; next state IDLE.
REQ-028 Minimum latency, zero-wait slave: req at cycle 0 -> VALID at cycle 1 -> B/R handshake at cycle 2 -> ack at cycle 3; next grant evaluated at cycle 4.
REQ-029 m_AWPROT and m_ARPROT are constant 3'b000.
REQ-030 VALID outputs never drop before their handshake; address and data stay stable while VALID is high.
REQ-031 One transaction in flight; requests arriving while busy wait, unacked.
REQ-032 A req deasserted before its ack is a protocol violation; behaviour is undefined, no recovery required.
REQ-033 busy=1 in every state except IDLE.

Reset
REQ-034 rst asserted: state IDLE, pointer 0, grant_idx 0, all VALID/READY/ack outputs 0, ack_rdata/ack_resp 0, captured registers 0; takes effect immediately, also mid-transaction.
REQ-035 First grant is possible on the first rising edge after rst deasserts.

Structure
REQ-036 Shared package axi_lite_pkg holds resp codes (OKAY=2'b00, SLVERR=2'b10), the state enum and default widths.
REQ-037 One sub-module, rr_arbiter (N-way round-robin, combinational pick plus registered pointer), is instantiated once.

Verification
REQ-038 Single write, req[0], addr 0x10, data 0xDEADBEEF, zero-wait slave -> AWVALID and WVALID at cycle 1, ack[0] at cycle 3, ack_resp OKAY.
REQ-039 Read of 0x10 after that write, req[1] -> ARADDR 0x10, ack[1] with ack_rdata 0xDEADBEEF.
REQ-040 req[0] and req[1] asserted together, held for 4 transactions -> grant order 0,1,0,1.
REQ-041 Slave asserts WREADY 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID stays high, single ack.
REQ-042 Slave returns BRESP 2'b10 -> ack_resp 2'b10 with ack.
REQ-043 rst pulsed while in RD_DATA -> all outputs 0 within the cycle, no ack, next request serviced normally.
